// File: rtl/oled_pkg.sv
// Shared constants for the OLED board composer: board geometry, cell codes,
// ASCII glyphs and the frame sequencer state encoding.
package oled_pkg;

  localparam int CHAR_ROWS  = 4;
  localparam int CHAR_COLS  = 16;
  localparam int CHAR_COUNT = CHAR_ROWS * CHAR_COLS;
  localparam int MSG_W      = 512;

  localparam logic [3:0] CELL_MINE    = 4'd9;
  localparam logic [3:0] CELL_FLAG    = 4'd10;
  localparam logic [3:0] CELL_COVERED = 4'd11;
  localparam logic [3:0] CELL_BADFLAG = 4'd12;

  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_ZERO       = 8'h30;
  localparam logic [7:0] ASCII_STAR       = 8'h2A;
  localparam logic [7:0] ASCII_F          = 8'h46;
  localparam logic [7:0] ASCII_DOT        = 8'h2E;
  localparam logic [7:0] ASCII_X          = 8'h58;
  localparam logic [7:0] ASCII_QMARK      = 8'h3F;
  localparam logic [7:0] ASCII_UNDERSCORE = 8'h5F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FLUSH,
    ST_SEND,
    ST_RELEASE
  } state_t;

endpackage

// File: rtl/cell_glyph.sv
// Maps one board cell code to its display character; a cursor hit
// overrides the cell with an underscore.
module cell_glyph
  import oled_pkg::*;
(
  input  logic [3:0] cell_code,
  input  logic       cursor_hit,
  output logic [7:0] glyph
);

  always_comb begin
    glyph = ASCII_QMARK;
    if (cursor_hit) begin
      glyph = ASCII_UNDERSCORE;
    end else if (cell_code == 4'd0) begin
      glyph = ASCII_SPACE;
    end else if (cell_code <= 4'd8) begin
      glyph = ASCII_ZERO + {4'd0, cell_code};
    end else begin
      case (cell_code)
        CELL_MINE:    glyph = ASCII_STAR;
        CELL_FLAG:    glyph = ASCII_F;
        CELL_COVERED: glyph = ASCII_DOT;
        CELL_BADFLAG: glyph = ASCII_X;
        default:      glyph = ASCII_QMARK;
      endcase
    end
  end

endmodule

// File: rtl/oled_board_composer.sv
// Renders the 4x16 board RAM into a 64-character message and hands it to the
// OLED wrapper over an enable/done handshake, with a blinking cursor overlay.
module oled_board_composer
  import oled_pkg::*;
#(
  parameter int BLINK_CYCLES = 50000000,
  parameter int BLINK_W      = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update_req,
  input  logic [1:0]       cursor_row,
  input  logic [3:0]       cursor_col,
  output logic             cell_rd,
  output logic [5:0]       cell_addr,
  input  logic [3:0]       cell_data,
  output logic [0:MSG_W-1] msg,
  output logic             disp_enable,
  input  logic             disp_done,
  output logic             busy
);

  state_t state;
  state_t state_next;

  logic [5:0]         idx;
  logic [5:0]         cursor_idx;
  logic               pending;
  logic [BLINK_W-1:0] blink_cnt;
  logic               cursor_phase;
  logic               blink_tick;
  logic               start_frame;
  logic               char_we;
  logic [5:0]         char_idx;
  logic               cursor_hit;
  logic [7:0]         glyph;

  assign blink_tick = (blink_cnt == BLINK_W'(BLINK_CYCLES - 1));
  assign busy       = (state != ST_IDLE);

  // The RAM answers one cycle late, so FETCH writes the cell fetched on the
  // previous cycle and FLUSH drains the last one.
  always_comb begin
    state_next  = state;
    cell_rd     = 1'b0;
    cell_addr   = 6'd0;
    disp_enable = 1'b0;
    start_frame = 1'b0;
    char_we     = 1'b0;
    char_idx    = idx - 6'd1;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          start_frame = 1'b1;
          state_next  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        cell_rd   = 1'b1;
        cell_addr = idx;
        char_we   = (idx != 6'd0);
        if (idx == 6'd63) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        char_we    = 1'b1;
        char_idx   = 6'd63;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        disp_enable = 1'b1;
        if (disp_done) begin
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!disp_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A request landing on the same edge a frame starts still counts: the set
  // term wins so that request produces one more frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= 6'd0;
      cursor_idx   <= 6'd0;
      pending      <= 1'b1;
      blink_cnt    <= '0;
      cursor_phase <= 1'b0;
    end else begin
      state     <= state_next;
      blink_cnt <= blink_tick ? '0 : blink_cnt + BLINK_W'(1);
      if (blink_tick) begin
        cursor_phase <= ~cursor_phase;
      end
      pending <= (pending & ~start_frame) | update_req | blink_tick;
      if (start_frame) begin
        idx        <= 6'd0;
        cursor_idx <= {cursor_row, cursor_col};
      end else if (state == ST_FETCH && idx != 6'd63) begin
        idx <= idx + 6'd1;
      end
    end
  end

  assign cursor_hit = cursor_phase && (char_idx == cursor_idx);

  cell_glyph u_glyph (
    .cell_code  (cell_data),
    .cursor_hit (cursor_hit),
    .glyph      (glyph)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      msg <= {CHAR_COUNT{ASCII_SPACE}};
    end else if (char_we) begin
      msg[{char_idx, 3'b000} +: 8] <= glyph;
    end
  end

endmodule

// File: tb/tb_oled_board_composer.sv
// Bench for oled_board_composer: a frame-timeline model checked every cycle,
// plus directed scenarios with hand-computed cycle numbers and characters.
module tb_oled_board_composer;
  import oled_pkg::*;

  localparam int B_MAIN = 300;
  localparam int B_FAST = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         update_req = 1'b0;
  logic [1:0]   cursor_row = 2'd0;
  logic [3:0]   cursor_col = 4'd0;
  logic         cell_rd;
  logic [5:0]   cell_addr;
  logic [3:0]   cell_data = 4'd0;
  logic [0:511] msg;
  logic         disp_enable;
  logic         disp_done = 1'b0;
  logic         busy;

  logic         reset2 = 1'b1;
  logic         cell_rd2;
  logic [5:0]   cell_addr2;
  logic [0:511] msg2;
  logic         disp_enable2;
  logic         disp_done2 = 1'b0;
  logic         busy2;

  logic [3:0] ram [64];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  int resp_mode = 0;
  int resp_delay = 3;
  int en_cnt = 0;
  int hold = 0;
  bit en_last = 1'b0;

  always #5 clk = ~clk;

  oled_board_composer #(.BLINK_CYCLES(B_MAIN), .BLINK_W(9)) dut (
    .clk(clk), .reset(reset), .update_req(update_req),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .cell_rd(cell_rd), .cell_addr(cell_addr), .cell_data(cell_data),
    .msg(msg), .disp_enable(disp_enable), .disp_done(disp_done), .busy(busy)
  );

  oled_board_composer #(.BLINK_CYCLES(B_FAST), .BLINK_W(4)) dut_fast (
    .clk(clk), .reset(reset2), .update_req(1'b0),
    .cursor_row(2'd0), .cursor_col(4'd0),
    .cell_rd(cell_rd2), .cell_addr(cell_addr2), .cell_data(4'd11),
    .msg(msg2), .disp_enable(disp_enable2), .disp_done(disp_done2), .busy(busy2)
  );

  always @(posedge clk) begin
    if (cell_rd) cell_data <= ram[cell_addr];
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Display wrapper stand-ins: delayed pulse, 10-cycle level, or done already
  // high when SEND is entered.
  always @(negedge clk) begin
    if (reset) begin
      en_cnt = 0; hold = 0; disp_done = 1'b0;
    end else begin
      case (resp_mode)
        0: begin
          en_cnt = disp_enable ? en_cnt + 1 : 0;
          disp_done = (en_cnt == resp_delay);
        end
        1: begin
          if (disp_enable && hold == 0 && !disp_done) hold = 10;
          if (hold > 0) begin disp_done = 1'b1; hold--; end
          else disp_done = 1'b0;
        end
        2: disp_done = busy && !en_last;
        default: disp_done = 1'b0;
      endcase
    end
    en_last = disp_enable;
    disp_done2 = reset2 ? 1'b0 : disp_enable2;
  end

  // Model: frame time m_t counts edges since a frame began; char j lands at
  // m_t = j+2 and the handshake opens at m_t = 65.
  string glyphs = " 12345678*F.X???";
  logic [7:0] m_msg [64];
  int m_t = -1;
  int m_hs = 0;
  int m_k = 0;
  int m_cur = 0;
  bit m_pending = 1'b1;
  bit m_phase = 1'b0;
  bit m_rst = 1'b1;
  bit m_tick, m_start;

  function automatic logic [7:0] render(input int j);
    if (m_phase && j == m_cur) return 8'h5F;
    return glyphs[int'(ram[j])];
  endfunction

  always @(posedge clk) begin
    m_rst = reset;
    if (reset) begin
      m_t = -1; m_hs = 0; m_k = 0; m_pending = 1'b1; m_phase = 1'b0;
      for (int i = 0; i < 64; i++) m_msg[i] = 8'h20;
    end else begin
      m_tick = (m_k % B_MAIN) == B_MAIN - 1;
      m_k++;
      m_start = 1'b0;
      if (m_t >= 0) begin
        m_t++;
        if (m_t >= 2) m_msg[m_t - 2] = render(m_t - 2);
        if (m_t == 65) begin m_t = -1; m_hs = 1; end
      end else if (m_hs == 1) begin
        if (disp_done) m_hs = 2;
      end else if (m_hs == 2) begin
        if (!disp_done) m_hs = 0;
      end else if (m_pending) begin
        m_start = 1'b1; m_t = 0; m_cur = int'(cursor_row) * 16 + int'(cursor_col);
      end
      m_pending = (m_pending && !m_start) || update_req || m_tick;
      if (m_tick) m_phase = !m_phase;
    end
  end

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    logic [0:511] e;
    for (int i = 0; i < 64; i++) e[8*i +: 8] = m_msg[i];
    checkOutput("model_msg", msg, e);
    checkOutput("model_cell_rd", cell_rd, m_t >= 0 && m_t <= 63);
    if (m_t >= 0 && m_t <= 63) checkOutput("model_cell_addr", cell_addr, m_t);
    else if (m_rst) checkOutput("model_cell_addr_rst", cell_addr, 0);
    checkOutput("model_enable", disp_enable, m_hs == 1);
    checkOutput("model_busy", busy, m_t >= 0 || m_hs != 0);
  end

  task automatic applyStimulus(input bit rst, input bit req);
    reset = rst;
    update_req = req;
    @(negedge clk);
  endtask

  task automatic doReset(input int mode, input int delay);
    resp_mode = mode;
    resp_delay = delay;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    reset = 1'b0;
  endtask

  // sel 0: enable high, 1: busy low
  task automatic waitFor(input string name, input int sel, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0 && disp_enable) || (sel == 1 && !busy)) return;
    end
    total++; bad++;
    $display("[TB] FAIL %s: condition not reached within %0d cycles", name, budget);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [0:127] row0_exp;
    logic [0:511] snap;
    int rd_count, addr_errs, en_rises, first_rd, busy_low, run;
    bit prev_en;
    int rise_cyc [4];
    logic [7:0] cur_ch [4];
    int exp_rise [4];
    logic [7:0] exp_ch [4];
    int nb, ne;
    bit pb, pe;

    // reset-drawn frame of an all-covered board
    for (int i = 0; i < 64; i++) ram[i] = 4'd11;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_msg", msg, {64{8'h20}});
    checkOutput("rst_enable", disp_enable, 0);
    checkOutput("rst_cell_rd", cell_rd, 0);
    checkOutput("rst_cell_addr", cell_addr, 0);
    checkOutput("rst_busy", busy, 0);
    reset = 1'b0;
    waitFor("t1_enable", 0, 200);
    checkOutput("t1_enable_cycle", cyc, 66);
    checkOutput("t1_msg_dots", msg, {64{8'h2E}});
    waitFor("t1_busy_low", 1, 50);
    checkOutput("t1_busy_low_cycle", cyc, 70);

    // glyph table and cursor blink
    for (int i = 0; i < 64; i++) ram[i] = 4'(i % 16);
    cursor_row = 2'd2; cursor_col = 4'd5;
    doReset(0, 3);
    waitFor("t2_enable", 0, 200);
    row0_exp = " 12345678*F.X???";
    checkOutput("t2_row0", msg[0:127], row0_exp);
    checkOutput("t2_char37", msg[296 +: 8], 8'h35);
    snap = msg;
    snap[296 +: 8] = 8'h5F;
    waitFor("t2_busy_low", 1, 50);
    waitFor("t2_blink_enable", 0, 400);
    checkOutput("t2_char37_blink", msg[296 +: 8], 8'h5F);
    checkOutput("t2_others_same", msg, snap);
    cursor_row = 2'd0; cursor_col = 4'd0;

    // three requests during SEND yield exactly one more frame
    for (int i = 0; i < 64; i++) ram[i] = 4'd11;
    doReset(0, 8);
    waitFor("t3_enable", 0, 200);
    checkOutput("t3_enable_cycle", cyc, 66);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
    end
    rd_count = 0; addr_errs = 0; en_rises = 0; prev_en = 1'b1;
    for (int i = 0; i < 175; i++) begin
      @(negedge clk);
      if (cell_rd) begin
        if (int'(cell_addr) != rd_count) addr_errs++;
        rd_count++;
      end
      if (disp_enable && !prev_en) en_rises++;
      prev_en = disp_enable;
    end
    checkOutput("t3_rd_cycles", rd_count, 64);
    checkOutput("t3_addr_order_errs", addr_errs, 0);
    checkOutput("t3_extra_frames", en_rises, 1);

    // done held as a level: RELEASE waits for it to drop
    doReset(1, 0);
    waitFor("t4_enable", 0, 200);
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    update_req = 1'b0;
    first_rd = -1; busy_low = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && busy_low < 0) busy_low = cyc;
      if (cell_rd && first_rd < 0) first_rd = cyc;
    end
    checkOutput("t4_busy_low_cycle", busy_low, 77);
    checkOutput("t4_next_frame_cycle", first_rd, 78);

    // done already high on entry to SEND and ignored during FETCH
    doReset(2, 0);
    waitFor("t4b_enable", 0, 200);
    checkOutput("t4b_enable_cycle", cyc, 66);
    run = 0;
    while (disp_enable && run < 20) begin
      run++;
      @(negedge clk);
    end
    checkOutput("t4b_enable_width", run, 1);

    // reset in the middle of FETCH
    doReset(0, 3);
    for (int i = 0; i < 100 && !(cell_rd && cell_addr == 6'd30); i++) @(negedge clk);
    checkOutput("t5_idx30_cycle", cyc, 31);
    checkOutput("t5_char0_written", msg[0:7], 8'h2E);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_abort_enable", disp_enable, 0);
    checkOutput("t5_abort_cell_rd", cell_rd, 0);
    checkOutput("t5_abort_msg", msg, {64{8'h20}});
    checkOutput("t5_abort_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_restart_rd", cell_rd, 1);
    checkOutput("t5_restart_addr", cell_addr, 0);

    // fast blink instance: back-to-back frames, cursor alternates
    exp_rise = '{1, 69, 137, 205};
    exp_ch = '{8'h2E, 8'h2E, 8'h5F, 8'h5F};
    for (int i = 0; i < 4; i++) begin rise_cyc[i] = -1; cur_ch[i] = 8'h00; end
    reset2 = 1'b1;
    repeat (2) @(negedge clk);
    reset2 = 1'b0;
    nb = 0; ne = 0; pb = 1'b0; pe = 1'b0;
    for (int n = 1; n <= 280; n++) begin
      @(negedge clk);
      if (busy2 && !pb && nb < 4) begin rise_cyc[nb] = n; nb++; end
      if (disp_enable2 && !pe && ne < 4) begin cur_ch[ne] = msg2[0:7]; ne++; end
      pb = busy2;
      pe = disp_enable2;
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t6_frame_start_%0d", i), rise_cyc[i], exp_rise[i]);
      checkOutput($sformatf("t6_cursor_char_%0d", i), cur_ch[i], exp_ch[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
